wm8731_i2c_cmd_arbiter: RTL and testbench
=========================================

// Module: wm8731_i2c_cmd_arbiter
// PURPOSE
//  Shares the single WM8731 I2C configuration controller between two command sources:
//  A = boot-time register-init sequencer, B = runtime control (volume, mute, input select).
//  Grants requesters round-robin, frames each 16-bit {reg[6:0],data[8:0]} word as
//  {SLAVE_ADDR,word}, drives the controller GO/END/ACK handshake, retries NACKs, times out hangs.
//  Sits between the control logic and the I2C controller instance, in the iCLK_50 domain.
// PARAMETERS
//  SLAVE_ADDR   8'h34  codec write address placed in oI2C_DATA[23:16]
//  MAX_RETRY    3      re-issues after the first NACK/timeout before reporting error (0..15)
//  TIMEOUT_TK   1024   ticks in WAIT with no iI2C_END before the transfer counts as failed
// PORTS
//  iCLK_50       in   1   system clock
//  iRST          in   1   synchronous, active-high reset
//  iTICK         in   1   one-cycle strobe at the I2C controller clock rate; FSM advances only on it
//  iREQ_A_VALID  in   1   requester A has a command; held until accepted
//  iREQ_A_DATA   in   16  requester A command {reg addr[6:0], data[8:0]}
//  oREQ_A_READY  out  1   1-cycle pulse: A's command accepted this cycle
//  oREQ_A_DONE   out  1   1-cycle pulse: A's command written and acknowledged
//  oREQ_A_ERR    out  1   1-cycle pulse: A's command abandoned after retries exhausted
//  iREQ_B_VALID, iREQ_B_DATA, oREQ_B_READY, oREQ_B_DONE, oREQ_B_ERR   as A, for requester B
//  oI2C_DATA     out  24  {SLAVE_ADDR, command}; stable from accept until DONE/ERR
//  oI2C_GO       out  1   start request to I2C controller
//  iI2C_END      in   1   controller transfer finished (sampled on iTICK only)
//  iI2C_ACK      in   1   controller ack status at END: 0 = all bytes acked, 1 = NACK (failure)
//  oBUSY         out  1   1 whenever state != IDLE
//  oGRANT        out  1   owner of current/last transfer: 0 = A, 1 = B
// BEHAVIOUR
//  Reset (iRST=1 at posedge): state=IDLE; all outputs 0; last_grant=B so A wins first contention;
//   retry_cnt=0, timer=0. Reset mid-transfer drops GO next cycle; no DONE/ERR pulse is emitted.
//  States: IDLE, ISSUE, WAIT, DONE, ERR. No transitions on cycles with iTICK=0 except DONE/ERR.
//  IDLE  (tick): if neither valid, stay. If one valid, grant it; if both, grant != last_grant.
//   Same cycle: READY pulse for winner, latch oI2C_DATA, oGRANT, retry_cnt=0 -> ISSUE.
//   No READY while busy; a VALID seen during a transfer waits in the requester.
//  ISSUE (tick): oI2C_GO<=1, timer<=0 -> WAIT.
//  WAIT  (tick): if iI2C_END: oI2C_GO<=0;
//    iI2C_ACK=0 -> DONE;
//    iI2C_ACK=1 and retry_cnt<MAX_RETRY -> retry_cnt++, -> ISSUE (GO low >= 1 tick before re-issue);
//    iI2C_ACK=1 and retry_cnt==MAX_RETRY -> ERR.
//   else if timer==TIMEOUT_TK-1: oI2C_GO<=0, handled as NACK (same retry/ERR rules); else timer++.
//  DONE: one clock (no tick needed): DONE pulse for oGRANT owner, last_grant<=oGRANT -> IDLE.
//  ERR:  one clock: ERR pulse for oGRANT owner, last_grant<=oGRANT -> IDLE.
//  Exactly one of DONE/ERR per accepted command; never both; never for the non-granted side.
//  END and timeout on the same tick: END wins. END while in IDLE/ISSUE: ignored.
//  Min latency READY->DONE: 3 ticks + 1 clk (accept, ISSUE, END tick, DONE).
//  Counters: timer width clog2(TIMEOUT_TK), retry_cnt 4 bits; neither wraps (bounded by FSM).
// TESTING
//  A only, data 16'h0C02, model acks after 5 ticks -> oI2C_DATA=24'h340C02, 1 READY_A, 1 DONE_A, no ERR.
//  A and B valid in same IDLE tick after reset -> A granted first, B granted next; then alternation A,B,A.
//  Model NACKs twice then acks (MAX_RETRY=3) -> GO rises 3 times, each separated by >=1 tick low, DONE_A once.
//  Model always NACKs -> 4 GO pulses (1+MAX_RETRY), then ERR_B once, oBUSY low, next request served.
//  Model never asserts END -> GO drops after TIMEOUT_TK ticks, retries, ERR after 4*TIMEOUT_TK ticks.
//  iRST asserted in WAIT -> next cycle GO=0, BUSY=0, no DONE/ERR; post-reset request completes normally.

Source files
------------

// File: rtl/wm8731_i2c_cmd_arbiter_if.sv
// Purpose : signal bundle between the two WM8731 command sources, the I2C controller and the arbiter.
// Latency : none (wires only).
// Backpressure: requesters hold *_VALID/*_DATA until their READY pulse; the controller ends a transfer with END/ACK.
// Ports (grouped here):
//   iTICK                          I2C-rate strobe, the arbiter FSM only advances on it
//   iREQ_x_VALID/DATA              command from requester x (A = init sequencer, B = runtime control)
//   oREQ_x_READY/DONE/ERR          1-cycle accept / acknowledged / abandoned pulses back to requester x
//   oI2C_DATA/GO, iI2C_END/ACK     I2C controller handshake
//   oBUSY, oGRANT                  arbiter status: not idle, owner of current/last transfer (0 = A, 1 = B)
interface wm8731_i2c_cmd_arbiter_if;
  logic        iTICK;
  logic        iREQ_A_VALID;
  logic [15:0] iREQ_A_DATA;
  logic        oREQ_A_READY;
  logic        oREQ_A_DONE;
  logic        oREQ_A_ERR;
  logic        iREQ_B_VALID;
  logic [15:0] iREQ_B_DATA;
  logic        oREQ_B_READY;
  logic        oREQ_B_DONE;
  logic        oREQ_B_ERR;
  logic [23:0] oI2C_DATA;
  logic        oI2C_GO;
  logic        iI2C_END;
  logic        iI2C_ACK;
  logic        oBUSY;
  logic        oGRANT;

  // master: the arbiter itself
  modport master (
    input  iTICK,
    input  iREQ_A_VALID, iREQ_A_DATA, iREQ_B_VALID, iREQ_B_DATA,
    output oREQ_A_READY, oREQ_A_DONE, oREQ_A_ERR,
    output oREQ_B_READY, oREQ_B_DONE, oREQ_B_ERR,
    output oI2C_DATA, oI2C_GO,
    input  iI2C_END, iI2C_ACK,
    output oBUSY, oGRANT
  );

  // slave: the requesters and the I2C controller, seen from outside the arbiter
  modport slave (
    output iTICK,
    output iREQ_A_VALID, iREQ_A_DATA, iREQ_B_VALID, iREQ_B_DATA,
    input  oREQ_A_READY, oREQ_A_DONE, oREQ_A_ERR,
    input  oREQ_B_READY, oREQ_B_DONE, oREQ_B_ERR,
    input  oI2C_DATA, oI2C_GO,
    output iI2C_END, iI2C_ACK,
    input  oBUSY, oGRANT
  );
endinterface

// File: rtl/wm8731_i2c_cmd_arbiter.sv
// Purpose : round-robin share of one WM8731 I2C write controller between init sequencer (A) and runtime control (B).
// Latency : READY->DONE at least 3 ticks + 1 clk; NACK/timeout re-issues up to MAX_RETRY times before ERR.
// Backpressure: one command in flight; no READY while busy, so a VALID raised mid-transfer waits in its requester.
// Ports:
//   iCLK_50  system clock
//   iRST     synchronous active-high reset
//   bus      wm8731_i2c_cmd_arbiter_if.master (requester handshakes, controller GO/END/ACK, BUSY/GRANT)
module wm8731_i2c_cmd_arbiter #(
  parameter logic [7:0] SLAVE_ADDR = 8'h34,
  parameter int         MAX_RETRY  = 3,
  parameter int         TIMEOUT_TK = 1024
) (
  input logic                      iCLK_50,
  input logic                      iRST,
  wm8731_i2c_cmd_arbiter_if.master bus
);

  localparam int                TimerW    = (TIMEOUT_TK > 1) ? $clog2(TIMEOUT_TK) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_TK - 1);
  localparam logic [3:0]        RetryMax  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t            state, stateNxt;
  logic              i2cGo, i2cGoNxt;
  logic [23:0]       i2cData, i2cDataNxt;
  logic              grant, grantNxt;
  logic              lastGrant, lastGrantNxt;
  logic [3:0]        retryCnt, retryCntNxt;
  logic [TimerW-1:0] timer, timerNxt;

  logic pickB;
  logic xferEnd;
  logic xferFail;
  logic readyA, readyB, doneA, doneB, errA, errB;

  // Single requester wins outright; on contention the side not served last time wins.
  assign pickB = bus.iREQ_B_VALID && (!bus.iREQ_A_VALID || !lastGrant);

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state     <= IDLE;
      i2cGo     <= 1'b0;
      i2cData   <= '0;
      grant     <= 1'b0;
      lastGrant <= 1'b1;   // pretend B went last so A wins the first contention
      retryCnt  <= '0;
      timer     <= '0;
    end else begin
      state     <= stateNxt;
      i2cGo     <= i2cGoNxt;
      i2cData   <= i2cDataNxt;
      grant     <= grantNxt;
      lastGrant <= lastGrantNxt;
      retryCnt  <= retryCntNxt;
      timer     <= timerNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    i2cGoNxt     = i2cGo;
    i2cDataNxt   = i2cData;
    grantNxt     = grant;
    lastGrantNxt = lastGrant;
    retryCntNxt  = retryCnt;
    timerNxt     = timer;
    xferEnd      = 1'b0;
    xferFail     = 1'b0;
    readyA       = 1'b0;
    readyB       = 1'b0;
    doneA        = 1'b0;
    doneB        = 1'b0;
    errA         = 1'b0;
    errB         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.iTICK && (bus.iREQ_A_VALID || bus.iREQ_B_VALID)) begin
          readyA      = !pickB;
          readyB      = pickB;
          grantNxt    = pickB;
          i2cDataNxt  = {SLAVE_ADDR, (pickB ? bus.iREQ_B_DATA : bus.iREQ_A_DATA)};
          retryCntNxt = '0;
          stateNxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.iTICK) begin
          i2cGoNxt = 1'b1;
          timerNxt = '0;
          stateNxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.iTICK) begin
          // END outranks a timeout landing on the same tick.
          if (bus.iI2C_END) begin
            xferEnd  = 1'b1;
            xferFail = bus.iI2C_ACK;
          end else if (timer == TimerLast) begin
            xferEnd  = 1'b1;
            xferFail = 1'b1;
          end else begin
            timerNxt = timer + TimerW'(1);
          end
          // GO drops here and only rises again on the next ISSUE tick,
          // so a retry always sees GO low for at least one tick.
          if (xferEnd) begin
            i2cGoNxt = 1'b0;
            if (!xferFail) begin
              stateNxt = DONE;
            end else if (retryCnt < RetryMax) begin
              retryCntNxt = retryCnt + 4'd1;
              stateNxt    = ISSUE;
            end else begin
              stateNxt = ERR;
            end
          end
        end
      end
      DONE: begin
        doneA        = !grant;
        doneB        = grant;
        lastGrantNxt = grant;
        stateNxt     = IDLE;
      end
      ERR: begin
        errA         = !grant;
        errB         = grant;
        lastGrantNxt = grant;
        stateNxt     = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Pulses are masked during reset so an interrupted transfer never reports an outcome.
  assign bus.oREQ_A_READY = readyA && !iRST;
  assign bus.oREQ_B_READY = readyB && !iRST;
  assign bus.oREQ_A_DONE  = doneA && !iRST;
  assign bus.oREQ_B_DONE  = doneB && !iRST;
  assign bus.oREQ_A_ERR   = errA && !iRST;
  assign bus.oREQ_B_ERR   = errB && !iRST;
  assign bus.oI2C_DATA    = i2cData;
  assign bus.oI2C_GO      = i2cGo;
  assign bus.oBUSY        = (state != IDLE);
  assign bus.oGRANT       = grant;

endmodule

// File: tb/tb_wm8731_i2c_cmd_arbiter.sv
// Purpose : self-checking bench for wm8731_i2c_cmd_arbiter with a scripted I2C controller model.
// Latency : n/a.
// Backpressure: requesters hold VALID until READY, as the arbiter expects.
module tb_wm8731_i2c_cmd_arbiter;

  localparam int TICK_DIV = 4;
  localparam int RDY_A  = 0;
  localparam int RDY_B  = 1;
  localparam int DONE_A = 2;
  localparam int DONE_B = 3;
  localparam int ERR_A  = 4;
  localparam int ERR_B  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wm8731_i2c_cmd_arbiter_if bus ();

  wm8731_i2c_cmd_arbiter #(
    .SLAVE_ADDR (8'h34),
    .MAX_RETRY  (3),
    .TIMEOUT_TK (1024)
  ) dut (
    .iCLK_50 (clk),
    .iRST    (rst),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          gos;
    int          ticks;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   snapReq = 0;
  int   endReq  = 0;
  int   toutReq = 0;

  // controller model configuration, set by the stimulus
  int mDelay = 2;
  int mNacks = 0;
  bit mHang  = 1'b0;

  function automatic void pushExp(int kind, logic [23:0] data, int gos, int ticks);
    exp_t e;
    e.kind  = kind;
    e.data  = data;
    e.gos   = gos;
    e.ticks = ticks;
    expQ.push_back(e);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Tick generator and I2C controller model: END is raised on the mDelay-th tick
  // with GO high and held until GO drops; the first mNacks ENDs of a command NACK.
  initial begin
    int tcnt;
    int mCnt;
    int nackUsed;
    tcnt = 0;
    mCnt = 0;
    nackUsed = 0;
    bus.iTICK    = 1'b0;
    bus.iI2C_END = 1'b0;
    bus.iI2C_ACK = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
      bus.iTICK = (tcnt == 0);
      if (!bus.oBUSY) nackUsed = 0;
      if (rst) begin
        bus.iI2C_END = 1'b0;
        bus.iI2C_ACK = 1'b0;
        mCnt = 0;
      end else if (bus.iI2C_END) begin
        if (!bus.oI2C_GO) begin
          bus.iI2C_END = 1'b0;
          bus.iI2C_ACK = 1'b0;
        end
      end else if (!bus.oI2C_GO) begin
        mCnt = 0;
      end else if (bus.iTICK && !mHang) begin
        mCnt++;
        if (mCnt == mDelay) begin
          bus.iI2C_END = 1'b1;
          bus.iI2C_ACK = (nackUsed < mNacks);
          nackUsed++;
          mCnt = 0;
        end
      end
    end
  end

  // Monitor / scoreboard
  int goRises  = 0;
  int goLow    = 0;
  int tickCnt  = 0;
  int snapSeen = 0;
  int endSeen  = 0;
  int toutSeen = 0;
  bit goPrev   = 1'b0;
  bit inFlight = 1'b0;

  always @(negedge clk) begin
    logic [5:0] p;
    exp_t       e;
    p = {bus.oREQ_B_ERR, bus.oREQ_A_ERR, bus.oREQ_B_DONE, bus.oREQ_A_DONE,
         bus.oREQ_B_READY, bus.oREQ_A_READY};

    if (snapReq != snapSeen) begin
      snapSeen = snapReq;
      check("reset_busy", {31'd0, bus.oBUSY}, 32'd0);
      check("reset_go", {31'd0, bus.oI2C_GO}, 32'd0);
      check("reset_grant", {31'd0, bus.oGRANT}, 32'd0);
      check("reset_data", {8'd0, bus.oI2C_DATA}, 32'd0);
      check("reset_pulses", {26'd0, p}, 32'd0);
    end
    if (toutReq != toutSeen) begin
      nChecks += toutReq - toutSeen;
      nFails  += toutReq - toutSeen;
      $display("FAIL wait_bound: %0d waits expired, required 0", toutReq - toutSeen);
      toutSeen = toutReq;
    end
    if (endReq != endSeen) begin
      endSeen = endReq;
      check("queue_drained", expQ.size(), 32'd0);
    end

    if (rst) begin
      goRises  = 0;
      goLow    = 0;
      goPrev   = 1'b0;
      inFlight = 1'b0;
      tickCnt  = 0;
    end else begin
      if (inFlight && bus.iTICK) tickCnt++;
      if (bus.oI2C_GO && !goPrev) begin
        if (goRises > 0) check("go_low_gap_ge_tick", {31'd0, goLow >= TICK_DIV}, 32'd1);
        goRises++;
        goLow = 0;
      end else if (!bus.oI2C_GO) begin
        goLow++;
      end
      goPrev = bus.oI2C_GO;

      for (int k = 0; k < 6; k++) begin
        if (p[k]) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected_pulse: got pulse kind %0d, required none", k);
          end else begin
            e = expQ.pop_front();
            check("pulse_kind", k, e.kind);
            if (k <= RDY_B) begin
              inFlight = 1'b1;
              tickCnt  = 0;
              goRises  = 0;
              goLow    = 0;
            end else begin
              check("i2c_data", {8'd0, bus.oI2C_DATA}, {8'd0, e.data});
              check("go_pulses", goRises, e.gos);
              check("ticks_accept_to_end", tickCnt, e.ticks);
              inFlight = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic req(input bit sideB, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    if (sideB) begin
      bus.iREQ_B_DATA  = d;
      bus.iREQ_B_VALID = 1'b1;
    end else begin
      bus.iREQ_A_DATA  = d;
      bus.iREQ_A_VALID = 1'b1;
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (sideB ? bus.oREQ_B_READY : bus.oREQ_A_READY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (sideB) bus.iREQ_B_VALID = 1'b0;
    else       bus.iREQ_A_VALID = 1'b0;
    if (!ok) toutReq++;
  endtask

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (!bus.oBUSY && expQ.size() == 0 && !bus.iREQ_A_VALID && !bus.iREQ_B_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) toutReq++;
  endtask

  initial begin
    bit goSeen;
    bus.iREQ_A_VALID = 1'b0;
    bus.iREQ_A_DATA  = '0;
    bus.iREQ_B_VALID = 1'b0;
    bus.iREQ_B_DATA  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    snapReq++;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // contention after reset: A first, then B (delay 2 -> 1 ISSUE + 2 WAIT ticks)
    mDelay = 2;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h341E00, 1, 3);
    pushExp(RDY_B, 24'h0, 0, 0);
    pushExp(DONE_B, 24'h340A17, 1, 3);
    fork
      req(1'b0, 16'h1E00);
      req(1'b1, 16'h0A17);
    join
    waitIdle(2000);

    // contention again at minimum latency: last was B, so A then B
    mDelay = 1;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h340497, 1, 2);
    pushExp(RDY_B, 24'h0, 0, 0);
    pushExp(DONE_B, 24'h340C00, 1, 2);
    fork
      req(1'b0, 16'h0497);
      req(1'b1, 16'h0C00);
    join
    waitIdle(2000);

    // A only, acked after 5 ticks
    mDelay = 5;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h340C02, 1, 6);
    req(1'b0, 16'h0C02);
    waitIdle(2000);

    // two NACKs then ack: 3 GO pulses, 3 * (1 + 3) ticks
    mDelay = 3;
    mNacks = 2;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h340E4A, 3, 12);
    req(1'b0, 16'h0E4A);
    waitIdle(2000);

    // always NACK on B: 4 GO pulses then ERR_B; next request still served
    mDelay = 2;
    mNacks = 100;
    pushExp(RDY_B, 24'h0, 0, 0);
    pushExp(ERR_B, 24'h340812, 4, 12);
    req(1'b1, 16'h0812);
    waitIdle(2000);
    mNacks = 0;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h341201, 1, 3);
    req(1'b0, 16'h1201);
    waitIdle(2000);

    // controller hangs: 4 attempts of 1 ISSUE + 1024 WAIT ticks, then ERR_A
    mHang = 1'b1;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(ERR_A, 24'h340A00, 4, 4100);
    req(1'b0, 16'h0A00);
    waitIdle(18000);

    // reset while waiting on the controller: GO/BUSY clear, no outcome pulse
    pushExp(RDY_A, 24'h0, 0, 0);
    req(1'b0, 16'h0C01);
    goSeen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.oI2C_GO) begin
        goSeen = 1'b1;
        break;
      end
    end
    if (!goSeen) toutReq++;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    snapReq++;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mHang  = 1'b0;
    mDelay = 2;
    pushExp(RDY_A, 24'h0, 0, 0);
    pushExp(DONE_A, 24'h340817, 1, 3);
    req(1'b0, 16'h0817);
    waitIdle(2000);

    @(posedge clk);
    #1;
    endReq++;
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
